// File: rtl/gp_regfile_sb.sv
// General-purpose register file: two combinational read ports, two write ports,
// and a one-bit-per-register pending-write scoreboard for the hazard unit.
module gp_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we0,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic              busy1,
    output logic              busy2,
    output logic              busy_any
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] reg_vals [DEPTH];
    logic [DEPTH-1:0]  pending;

    // A write to the hardwired-zero register is treated as never happening.
    logic wr0_ok;
    logic wr1_ok;
    assign wr0_ok = we0 && !(ZERO_REG && (waddr0 == '0));
    assign wr1_ok = we1 && !(ZERO_REG && (waddr1 == '0));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (ZERO_REG && (gi == 0)) begin : g_zero
                assign reg_vals[gi] = '0;
                assign pending[gi]  = 1'b0;
            end else begin : g_store
                logic [DATA_W-1:0] q_reg;
                logic              pend_reg;
                logic              hit0;
                logic              hit1;
                logic              hit_set;

                assign hit0    = we0 && (waddr0 == ADDR_W'(gi));
                assign hit1    = we1 && (waddr1 == ADDR_W'(gi));
                assign hit_set = sb_set && (sb_addr == ADDR_W'(gi));

                always_ff @(posedge clk) begin
                    if (reset) begin
                        q_reg <= '0;
                    end else if (hit1) begin
                        q_reg <= wdata1;
                    end else if (hit0) begin
                        q_reg <= wdata0;
                    end
                end

                // A new issue to this register outranks a writeback completing in the same cycle.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        pend_reg <= 1'b0;
                    end else if (hit_set) begin
                        pend_reg <= 1'b1;
                    end else if (hit0 || hit1) begin
                        pend_reg <= 1'b0;
                    end
                end

                assign reg_vals[gi] = q_reg;
                assign pending[gi]  = pend_reg;
            end
        end
    endgenerate

    logic [ADDR_W-1:0] raddr_v [2];
    logic [DATA_W-1:0] rdata_v [2];
    logic              busy_v  [2];

    assign raddr_v[0] = raddr1;
    assign raddr_v[1] = raddr2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            logic byp0;
            logic byp1;

            assign byp0 = BYPASS && !reset && wr0_ok && (waddr0 == raddr_v[gi]);
            assign byp1 = BYPASS && !reset && wr1_ok && (waddr1 == raddr_v[gi]);

            always_comb begin
                rdata_v[gi] = reg_vals[raddr_v[gi]];
                busy_v[gi]  = pending[raddr_v[gi]];
                if (ZERO_REG && (raddr_v[gi] == '0)) begin
                    rdata_v[gi] = '0;
                    busy_v[gi]  = 1'b0;
                end else if (byp1) begin
                    rdata_v[gi] = wdata1;
                    busy_v[gi]  = 1'b0;
                end else if (byp0) begin
                    rdata_v[gi] = wdata0;
                    busy_v[gi]  = 1'b0;
                end
            end
        end
    endgenerate

    assign rdata1   = rdata_v[0];
    assign rdata2   = rdata_v[1];
    assign busy1    = busy_v[0];
    assign busy2    = busy_v[1];
    assign busy_any = |pending;

endmodule

// File: tb/tb_gp_regfile_sb.sv
// Bench for gp_regfile_sb (default parameters): directed cases followed by random traffic,
// every cycle compared against an array-based model of the register file and scoreboard.
module tb_gp_regfile_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          we0, we1, sb_set;
    logic [AW-1:0] waddr0, waddr1, raddr1, raddr2, sb_addr;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] rdata1, rdata2;
    logic          busy1, busy2, busy_any;

    gp_regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .busy1(busy1), .busy2(busy2), .busy_any(busy_any)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem  [N];
    logic          pend [N];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (!reset && we1 && waddr1 == a) return wdata1;
        if (!reset && we0 && waddr0 == a) return wdata0;
        return mem[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (!reset && ((we1 && waddr1 == a) || (we0 && waddr0 == a))) return 1'b0;
        return pend[a];
    endfunction

    function automatic logic exp_busy_any();
        for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are stable here; compare, then let the edge happen and advance the model.
    task automatic tick(input bit do_check);
        #4;
        if (do_check) begin
            chk($sformatf("rdata1[a=%0d]", raddr1), rdata1, exp_rdata(raddr1));
            chk($sformatf("rdata2[a=%0d]", raddr2), rdata2, exp_rdata(raddr2));
            chk($sformatf("busy1[a=%0d]", raddr1), DW'(busy1), DW'(exp_busy(raddr1)));
            chk($sformatf("busy2[a=%0d]", raddr2), DW'(busy2), DW'(exp_busy(raddr2)));
            chk("busy_any", DW'(busy_any), DW'(exp_busy_any()));
        end
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mem[i]  = '0;
                pend[i] = 1'b0;
            end
        end else begin
            if (we0 && waddr0 != 0) begin mem[waddr0] = wdata0; pend[waddr0] = 1'b0; end
            if (we1 && waddr1 != 0) begin mem[waddr1] = wdata1; pend[waddr1] = 1'b0; end
            if (sb_set && sb_addr != 0) pend[sb_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; we0 = 1'b0; we1 = 1'b0; sb_set = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0; sb_addr = '0;
    endtask

    task automatic randomize_inputs(input int amax);
        we0     = 1'($urandom_range(0, 1));
        we1     = 1'($urandom_range(0, 1));
        sb_set  = 1'($urandom_range(0, 1));
        waddr0  = AW'($urandom_range(0, amax));
        waddr1  = ($urandom_range(0, 3) == 0) ? waddr0 : AW'($urandom_range(0, amax));
        sb_addr = ($urandom_range(0, 2) == 0) ? waddr1 : AW'($urandom_range(0, amax));
        wdata0  = $urandom;
        wdata1  = $urandom;
        raddr1  = ($urandom_range(0, 2) == 0) ? waddr0 : AW'($urandom_range(0, amax));
        raddr2  = ($urandom_range(0, 2) == 0) ? waddr1 : AW'($urandom_range(0, amax));
    endtask

    initial begin
        idle();
        raddr1 = '0; raddr2 = '0;
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        tick(1'b1);

        // Random writes, then a single reset cycle must clear everything.
        for (int i = 0; i < 12; i++) begin
            randomize_inputs(N - 1);
            tick(1'b1);
        end
        idle();
        reset = 1'b1; we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h1234_5678;
        sb_set = 1'b1; sb_addr = 5'd4;
        tick(1'b1);
        idle();
        for (int a = 0; a < N; a++) begin
            raddr1 = AW'(a);
            raddr2 = AW'(N - 1 - a);
            tick(1'b1);
        end

        // Same-cycle bypass of a port 0 write.
        idle();
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; raddr1 = 5'd5; raddr2 = 5'd6;
        tick(1'b1);
        idle();
        tick(1'b1);

        // Both ports to the same address: port 1 wins, also on the bypass path.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        raddr1 = 5'd7; raddr2 = 5'd7;
        tick(1'b1);
        idle();
        tick(1'b1);

        // Register 0 ignores writes and scoreboard sets.
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
        sb_set = 1'b1; sb_addr = 5'd0; raddr1 = 5'd0; raddr2 = 5'd0;
        tick(1'b1);
        idle();
        tick(1'b1);

        // Scoreboard: set, set-with-write (set wins), then write alone clears.
        raddr1 = 5'd3; raddr2 = 5'd9;
        sb_set = 1'b1; sb_addr = 5'd3;
        tick(1'b1);
        sb_set = 1'b1; sb_addr = 5'd3; we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'hA5A5_0003;
        tick(1'b1);
        idle();
        tick(1'b1);
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h0000_0333;
        tick(1'b1);
        idle();
        tick(1'b1);

        // Set under reset is discarded.
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99;
        tick(1'b1);
        idle();
        reset = 1'b1; sb_set = 1'b1; sb_addr = 5'd9; raddr1 = 5'd9;
        tick(1'b1);
        idle();
        raddr1 = 5'd9;
        tick(1'b1);

        // Random traffic over a narrow address range to force collisions.
        for (int i = 0; i < 400; i++) begin
            randomize_inputs((i < 200) ? 7 : N - 1);
            reset = ($urandom_range(0, 39) == 0);
            tick(1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
